// File: rtl/ftt_mult.sv
// ftt_mult: sequential 8x8 unsigned multiplier. Operands are split into 2-bit
// digits, zero padded to length 8, and convolved through a length-8 NTT
// modulo 257 (root 4). The resulting coefficients are recombined with carries.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | split latched operands into digits (bit-reversed order)
// FWD0-2 | forward butterfly stages, both operands in parallel
// PMUL   | pointwise product mod 257, stored bit-reversed for the inverse
// INV0-2 | inverse butterfly stages (root 4^-1)
// SCALE  | multiply by 8^-1 mod 257
// CARRY  | recombine coefficients into c, pulse done
module ftt_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] c,
  output logic        busy,
  output logic        done
);

  localparam int          N     = 8;
  localparam logic [9:0]  Q     = 10'd257;
  localparam logic [8:0]  N_INV = 9'd225;

  typedef logic [8:0]  res_t;
  typedef res_t [N-1:0] vec_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FWD0, S_FWD1, S_FWD2, S_PMUL,
    S_INV0, S_INV1, S_INV2, S_SCALE, S_CARRY
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, b_q;
  vec_t        x_q, y_q;
  logic [15:0] c_q;
  logic        busy_q, done_q;
  logic        accept;
  logic [15:0] carry_sum;

  // Fold a value of up to 24 bits into [0,256] using 2^8 = -1 (mod 257).
  function automatic res_t red24(input logic [23:0] p);
    logic signed [10:0] t;
    t = $signed({3'b000, p[7:0]}) - $signed({3'b000, p[15:8]})
      + $signed({3'b000, p[23:16]});
    if (t < 0)
      t = t + $signed({1'b0, Q});
    else if (t >= $signed({1'b0, Q}))
      t = t - $signed({1'b0, Q});
    return t[8:0];
  endfunction

  function automatic res_t add_mod(input res_t u, input res_t v);
    logic [9:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= Q) s = s - Q;
    return s[8:0];
  endfunction

  function automatic res_t sub_mod(input res_t u, input res_t v);
    logic [9:0] s;
    s = {1'b0, u} + Q - {1'b0, v};
    if (s >= Q) s = s - Q;
    return s[8:0];
  endfunction

  // Twiddles are powers of two, so multiplication is a shift then a fold.
  function automatic res_t shl_mod(input res_t x, input logic [3:0] k);
    return red24(24'(x) << k);
  endfunction

  function automatic res_t mul_mod(input res_t x, input res_t y);
    logic [17:0] p;
    p = 18'(x) * 18'(y);
    return red24({6'b0, p});
  endfunction

  function automatic int rev3(input int p);
    return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
  endfunction

  // One radix-2 DIT stage with half-span 2^lg. Forward twiddle 4^m = 2^(2m);
  // inverse twiddle 4^-m = 2^(16-2m) since 2^16 = 1 (mod 257).
  function automatic vec_t bfly(input vec_t v, input int lg, input logic inv);
    vec_t r;
    int   q, j, m, k;
    r = v;
    for (int p = 0; p < N; p++) begin
      if (((p >> lg) & 1) == 0) begin
        q = p + (1 << lg);
        j = p & ((1 << lg) - 1);
        m = j << (2 - lg);
        k = inv ? ((16 - 2 * m) & 15) : (2 * m);
        r[p] = add_mod(v[p], shl_mod(v[q], k[3:0]));
        r[q] = sub_mod(v[p], shl_mod(v[q], k[3:0]));
      end
    end
    return r;
  endfunction

  // A start arriving in the CARRY cycle is taken on the same edge that
  // delivers the result, giving one result every 10 cycles back to back.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_CARRY));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed walk through the pipeline of phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_FWD0;
      S_FWD0:  state_d = S_FWD1;
      S_FWD1:  state_d = S_FWD2;
      S_FWD2:  state_d = S_PMUL;
      S_PMUL:  state_d = S_INV0;
      S_INV0:  state_d = S_INV1;
      S_INV1:  state_d = S_INV2;
      S_INV2:  state_d = S_SCALE;
      S_SCALE: state_d = S_CARRY;
      S_CARRY: state_d = accept ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficients are at most 36, so plain shifted addition gives a*b.
  always_comb begin
    carry_sum = '0;
    for (int j = 0; j < N - 1; j++)
      carry_sum = carry_sum + (16'(x_q[j]) << (2 * j));
  end

  // Datapath: operand capture, transform stages and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        busy_q <= 1'b1;
      end
      case (state_q)
        S_LOAD: begin
          for (int p = 0; p < N; p++) begin
            if (rev3(p) < 4) begin
              x_q[p] <= {7'b0, a_q[2 * rev3(p) +: 2]};
              y_q[p] <= {7'b0, b_q[2 * rev3(p) +: 2]};
            end else begin
              x_q[p] <= '0;
              y_q[p] <= '0;
            end
          end
        end
        S_FWD0: begin x_q <= bfly(x_q, 0, 1'b0); y_q <= bfly(y_q, 0, 1'b0); end
        S_FWD1: begin x_q <= bfly(x_q, 1, 1'b0); y_q <= bfly(y_q, 1, 1'b0); end
        S_FWD2: begin x_q <= bfly(x_q, 2, 1'b0); y_q <= bfly(y_q, 2, 1'b0); end
        S_PMUL: begin
          for (int p = 0; p < N; p++)
            x_q[p] <= mul_mod(x_q[rev3(p)], y_q[rev3(p)]);
        end
        S_INV0: x_q <= bfly(x_q, 0, 1'b1);
        S_INV1: x_q <= bfly(x_q, 1, 1'b1);
        S_INV2: x_q <= bfly(x_q, 2, 1'b1);
        S_SCALE: begin
          for (int p = 0; p < N; p++)
            x_q[p] <= mul_mod(x_q[p], N_INV);
        end
        S_CARRY: begin
          c_q    <= carry_sum;
          done_q <= 1'b1;
          busy_q <= start;
        end
        default: ;
      endcase
    end
  end

  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ftt_mult.sv
// Directed and table-driven bench for ftt_mult.
module tb_ftt_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] c;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_rec_t;

  vec_rec_t tbl[12];

  ftt_mult dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One operation; operands scrambled while busy. Checks latency, busy, c.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input string name);
    int   cyc;
    logic got;
    logic busy_ok;
    logic [15:0] req;
    req = 16'(ta) * 16'(tb);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    busy_ok = busy;
    cyc = 0; got = 1'b0;
    while (cyc < 20 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({name, "_latency"}, got ? cyc : 0, 10);
    chk({name, "_c"}, c, req);
    chk({name, "_busy"}, {busy_ok, busy}, 2'b10);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int ndone, cyc;
    logic [7:0]  ba[4], bb[4];
    logic [15:0] bp[4];

    tbl[0]  = '{8'd124, 8'd201, 16'd24924};
    tbl[1]  = '{8'd255, 8'd255, 16'd65025};
    tbl[2]  = '{8'd0,   8'd173, 16'd0};
    tbl[3]  = '{8'd1,   8'd255, 16'd255};
    tbl[4]  = '{8'd16,  8'd16,  16'd256};
    tbl[5]  = '{8'd200, 8'd3,   16'd600};
    tbl[6]  = '{8'd17,  8'd15,  16'd255};
    tbl[7]  = '{8'd128, 8'd2,   16'd256};
    tbl[8]  = '{8'd170, 8'd85,  16'd14450};
    tbl[9]  = '{8'd99,  8'd101, 16'd9999};
    tbl[10] = '{8'd7,   8'd9,   16'd63};
    tbl[11] = '{8'd255, 8'd0,   16'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_c", c, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // Table: hand-computed products, checked against the constant column.
    for (int i = 0; i < 12; i++) begin
      int cyc2;
      logic got;
      @(negedge clk);
      start = 1'b1; a = tbl[i].a; b = tbl[i].b;
      @(posedge clk); #1;
      start = 1'b0; a = ~a; b = ~b;
      cyc2 = 0; got = 1'b0;
      while (cyc2 < 20 && !got) begin
        @(posedge clk); #1;
        cyc2++;
        if (done) got = 1'b1;
      end
      chk($sformatf("tbl%0d_latency", i), got ? cyc2 : 0, 10);
      chk($sformatf("tbl%0d_c", i), c, tbl[i].p);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin start = 1'b1; a = 8'd3; b = 8'd3; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("busy_start_cycle", k, 10);
        chk("busy_start_c", c, 20000);
      end
    end
    chk("busy_start_pulses", ndone, 1);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; a = 8'd50; b = 8'd60;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_c", c, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(8'd16, 8'd16, "after_abort");

    // Back to back with start held high.
    ba[0] = 8'd124; bb[0] = 8'd201; bp[0] = 16'd24924;
    ba[1] = 8'd255; bb[1] = 8'd255; bp[1] = 16'd65025;
    ba[2] = 8'd3;   bb[2] = 8'd7;   bp[2] = 16'd21;
    ba[3] = 8'd64;  bb[3] = 8'd128; bp[3] = 16'd8192;
    @(negedge clk);
    start = 1'b1; a = ba[0]; b = bb[0];
    @(posedge clk); #1;
    a = ba[1]; b = bb[1];
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!done && cyc < 20);
      chk($sformatf("b2b%0d_cycle", i), cyc, 10);
      chk($sformatf("b2b%0d_c", i), c, bp[i]);
      if (i + 2 < 4) begin a = ba[i+2]; b = bb[i+2]; end
      else start = 1'b0;
    end
    @(posedge clk); #1;

    // Grid sweep including both corners, then random pairs.
    for (int ia = 0; ia < 256; ia += 15)
      for (int ib = 0; ib < 256; ib += 15)
        do_op(8'(ia), 8'(ib), $sformatf("grid_%0d_%0d", ia, ib));
    for (int r = 0; r < 400; r++)
      do_op(8'($urandom), 8'($urandom), $sformatf("rand%0d", r));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
